shader_array_mem_ctrl: RTL and testbench

SHADER_ARRAY_MEM_CTRL -- requirements
Module: shader_array_mem_ctrl

---
 rtl/shader_array_mem_ctrl_if.sv | 29 ++
 rtl/shader_array_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_shader_array_mem_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shader_array_mem_ctrl_if.sv
// Core-side request/grant bus and data-RAM port of the shader array memory controller.
// The controller uses the slave modport; the cores and the RAM sit on the master side.
interface shader_array_mem_ctrl_if #(
  parameter int CORE_COUNT    = 4,
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16
);
  logic [CORE_COUNT-1:0]               core_req;
  logic [CORE_COUNT-1:0]               core_write;
  logic [CORE_COUNT*ADDRESS_WIDTH-1:0] core_address;
  logic [CORE_COUNT*WORD_WIDTH-1:0]    core_write_data;
  logic [CORE_COUNT-1:0]               core_grant;
  logic [CORE_COUNT-1:0]               core_rvalid;
  logic [WORD_WIDTH-1:0]               core_rdata;
  logic [ADDRESS_WIDTH-1:0]            ram_address;
  logic                                ram_write;
  logic [WORD_WIDTH-1:0]               ram_write_data;
  logic [WORD_WIDTH-1:0]               ram_read_data;

  modport slave (
    input  core_req, core_write, core_address, core_write_data, ram_read_data,
    output core_grant, core_rvalid, core_rdata, ram_address, ram_write, ram_write_data
  );

  modport master (
    output core_req, core_write, core_address, core_write_data, ram_read_data,
    input  core_grant, core_rvalid, core_rdata, ram_address, ram_write, ram_write_data
  );
endinterface

// File: rtl/shader_array_mem_ctrl.sv
// Shares one single-port data RAM between an external loader (run=0) and a set of
// round-robin arbitrated shader cores (run=1), plus run/halt/exception bookkeeping.
module shader_array_mem_ctrl #(
  parameter int  CORE_COUNT    = 4,
  parameter int  WORD_WIDTH    = 32,
  parameter int  ADDRESS_WIDTH = 16,
  localparam int IDX_WIDTH     = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     run,
  input  logic [ADDRESS_WIDTH-1:0] ext_write_address,
  input  logic [WORD_WIDTH-1:0]    ext_write_data,
  input  logic                     ext_enable_write_data,
  input  logic [CORE_COUNT-1:0]    core_halted,
  input  logic [CORE_COUNT-1:0]    core_exception,
  shader_array_mem_ctrl_if.slave   bus,
  output logic                     all_halted,
  output logic                     exception,
  output logic [IDX_WIDTH-1:0]     exception_core,
  output logic [31:0]              run_cycles
);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CORE_COUNT - 1);

  logic                     run_q;
  logic [IDX_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CORE_COUNT-1:0]    rvalid_q, rvalid_d;
  logic                     all_halted_q, all_halted_d;
  logic                     exception_q, exception_d;
  logic [IDX_WIDTH-1:0]     exception_core_q, exception_core_d;
  logic [31:0]              run_cycles_q, run_cycles_d;

  logic                     run_rise;
  logic [IDX_WIDTH-1:0]     ptr_eff;
  logic                     gnt_valid;
  logic [IDX_WIDTH-1:0]     gnt_idx;
  logic [CORE_COUNT-1:0]    grant_vec;
  logic [ADDRESS_WIDTH-1:0] gnt_address;
  logic [WORD_WIDTH-1:0]    gnt_write_data;
  logic                     gnt_write;
  logic [ADDRESS_WIDTH-1:0] byte_address;
  logic [IDX_WIDTH-1:0]     lowest_exc;

  // A run rising edge restarts arbitration from core 0 in that very cycle.
  assign run_rise = run & ~run_q;
  assign ptr_eff  = run_rise ? '0 : rr_ptr_q;

  always_comb begin : arbiter
    int cand;
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (run) begin
      for (int i = 0; i < CORE_COUNT; i++) begin
        cand = int'(ptr_eff) + i;
        if (cand >= CORE_COUNT) cand = cand - CORE_COUNT;
        if (!gnt_valid && bus.core_req[cand[IDX_WIDTH-1:0]]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand[IDX_WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin : operand_mux
    grant_vec      = '0;
    gnt_address    = '0;
    gnt_write_data = '0;
    gnt_write      = 1'b0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (gnt_valid && gnt_idx == IDX_WIDTH'(i)) begin
        grant_vec[i]   = 1'b1;
        gnt_address    = bus.core_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        gnt_write_data = bus.core_write_data[i*WORD_WIDTH +: WORD_WIDTH];
        gnt_write      = bus.core_write[i];
      end
    end
  end

  // The RAM is word addressed, so the two byte-offset bits are shifted away.
  always_comb begin : ram_mux
    byte_address       = ext_write_address;
    bus.ram_write      = ext_enable_write_data;
    bus.ram_write_data = ext_write_data;
    if (run) begin
      byte_address       = gnt_address;
      bus.ram_write      = gnt_write;
      bus.ram_write_data = gnt_write_data;
    end
    bus.ram_address = byte_address >> 2;
  end

  assign bus.core_grant  = grant_vec;
  assign bus.core_rvalid = rvalid_q;
  assign bus.core_rdata  = bus.ram_read_data;

  always_comb begin : exc_priority
    lowest_exc = '0;
    for (int i = CORE_COUNT - 1; i >= 0; i--) begin
      if (core_exception[i]) lowest_exc = IDX_WIDTH'(i);
    end
  end

  always_comb begin : next_state
    rr_ptr_d = ptr_eff;
    if (gnt_valid) rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_WIDTH'(1);
    rvalid_d     = grant_vec & ~bus.core_write;
    all_halted_d = run & (&core_halted);

    // Exception capture is sticky within a run; only a new run edge re-arms it.
    exception_d      = run_rise ? 1'b0 : exception_q;
    exception_core_d = run_rise ? '0 : exception_core_q;
    if (run && !exception_d && (|core_exception)) begin
      exception_d      = 1'b1;
      exception_core_d = lowest_exc;
    end

    run_cycles_d = run_rise ? '0 : run_cycles_q;
    if (run && !all_halted_q && run_cycles_d != '1) run_cycles_d = run_cycles_d + 32'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q            <= 1'b0;
      rr_ptr_q         <= '0;
      rvalid_q         <= '0;
      all_halted_q     <= 1'b0;
      exception_q      <= 1'b0;
      exception_core_q <= '0;
      run_cycles_q     <= '0;
    end else begin
      run_q            <= run;
      rr_ptr_q         <= rr_ptr_d;
      rvalid_q         <= rvalid_d;
      all_halted_q     <= all_halted_d;
      exception_q      <= exception_d;
      exception_core_q <= exception_core_d;
      run_cycles_q     <= run_cycles_d;
    end
  end

  assign all_halted     = all_halted_q;
  assign exception      = exception_q;
  assign exception_core = exception_core_q;
  assign run_cycles     = run_cycles_q;
endmodule

// File: tb/tb_shader_array_mem_ctrl.sv
// Self-checking bench for shader_array_mem_ctrl: directed vector tables, hand-written
// corner sequences and a randomized phase checked against a cycle-level reference model.
module tb_shader_array_mem_ctrl;
  localparam int N  = 4;
  localparam int WW = 32;
  localparam int AW = 16;
  localparam int IW = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          run;
  logic [AW-1:0] ext_write_address;
  logic [WW-1:0] ext_write_data;
  logic          ext_enable_write_data;
  logic [N-1:0]  core_halted;
  logic [N-1:0]  core_exception;
  logic          all_halted;
  logic          exception;
  logic [IW-1:0] exception_core;
  logic [31:0]   run_cycles;

  shader_array_mem_ctrl_if #(.CORE_COUNT(N), .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) bus ();

  shader_array_mem_ctrl #(.CORE_COUNT(N), .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .run                   (run),
    .ext_write_address     (ext_write_address),
    .ext_write_data        (ext_write_data),
    .ext_enable_write_data (ext_enable_write_data),
    .core_halted           (core_halted),
    .core_exception        (core_exception),
    .bus                   (bus),
    .all_halted            (all_halted),
    .exception             (exception),
    .exception_core        (exception_core),
    .run_cycles            (run_cycles)
  );

  always #5 clock = ~clock;

  // Behavioural 256-word RAM with one-cycle synchronous read.
  logic [WW-1:0] ram [256];
  always @(posedge clock) begin
    if (bus.ram_write) ram[bus.ram_address[7:0]] <= bus.ram_write_data;
    bus.ram_read_data <= ram[bus.ram_address[7:0]];
  end

  int n_checks;
  int n_fail;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model state
  bit            m_prev_run;
  int            m_ptr;
  int            m_pend_idx;
  logic [WW-1:0] m_pend_data;
  bit            m_allh;
  bit            m_exc;
  int            m_exc_core;
  longint        m_rc;
  logic [WW-1:0] m_mem [256];
  int            last_k;

  task automatic model_reset();
    m_prev_run = 1'b0;
    m_ptr      = 0;
    m_pend_idx = -1;
    m_allh     = 1'b0;
    m_exc      = 1'b0;
    m_exc_core = 0;
    m_rc       = 0;
    last_k     = -1;
  endtask

  task automatic model_step();
    bit            rise;
    int            ptr;
    int            k;
    int            w;
    int            low;
    logic [AW-1:0] a;
    logic [WW-1:0] d;
    logic [N-1:0]  exp_g;
    logic [N-1:0]  exp_rv;
    bit            wr;
    logic [WW-1:0] rd_data;
    rise = run && !m_prev_run;
    ptr  = rise ? 0 : m_ptr;
    k    = -1;
    if (run)
      for (int i = 0; i < N; i++)
        if (k < 0 && bus.core_req[(ptr + i) % N]) k = (ptr + i) % N;
    exp_g  = (k >= 0) ? N'(1 << k) : '0;
    exp_rv = (m_pend_idx >= 0) ? N'(1 << m_pend_idx) : '0;
    check_output("rnd_grant", 64'(bus.core_grant), 64'(exp_g));
    check_output("rnd_rvalid", 64'(bus.core_rvalid), 64'(exp_rv));
    if (m_pend_idx >= 0) check_output("rnd_rdata", 64'(bus.core_rdata), 64'(m_pend_data));
    check_output("rnd_all_halted", 64'(all_halted), 64'(m_allh));
    check_output("rnd_exception", 64'(exception), 64'(m_exc));
    check_output("rnd_exception_core", 64'(exception_core), 64'(m_exc_core));
    check_output("rnd_run_cycles", 64'(run_cycles), 64'(m_rc));

    wr = 1'b0;
    a  = '0;
    d  = '0;
    rd_data = 'x;
    if (!run) begin
      a  = ext_write_address;
      d  = ext_write_data;
      wr = ext_enable_write_data;
      check_output("rnd_ext_addr", 64'(bus.ram_address), 64'(a >> 2));
      check_output("rnd_ext_write", 64'(bus.ram_write), 64'(wr));
    end else if (k >= 0) begin
      a  = bus.core_address[k*AW +: AW];
      d  = bus.core_write_data[k*WW +: WW];
      wr = bus.core_write[k];
      check_output("rnd_core_addr", 64'(bus.ram_address), 64'(a >> 2));
      check_output("rnd_core_write", 64'(bus.ram_write), 64'(wr));
    end else begin
      check_output("rnd_idle_write", 64'(bus.ram_write), 64'd0);
    end
    w = int'(a[9:2]);
    if (wr) begin
      check_output("rnd_wdata", 64'(bus.ram_write_data), 64'(d));
    end
    rd_data = m_mem[w];
    if (wr) m_mem[w] = d;

    m_pend_idx  = (k >= 0 && !wr) ? k : -1;
    m_pend_data = rd_data;
    m_ptr       = (k >= 0) ? (k + 1) % N : ptr;
    last_k      = k;
    if (rise) begin
      m_exc      = 1'b0;
      m_exc_core = 0;
      m_rc       = 0;
    end
    if (run && !m_exc && core_exception != '0) begin
      low = 0;
      for (int i = N - 1; i >= 0; i--) if (core_exception[i]) low = i;
      m_exc      = 1'b1;
      m_exc_core = low;
    end
    if (run && !m_allh && m_rc < 64'hFFFF_FFFF) m_rc++;
    m_allh     = run && (core_halted == '1);
    m_prev_run = run;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic          en;
    logic [AW-1:0] exp_addr;
    logic          exp_write;
  } ext_vec_t;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] exp_grant;
  } arb_vec_t;

  ext_vec_t ext_vecs [5];
  arb_vec_t arb_vecs [9];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    ext_vecs[0] = '{16'h0010, 32'hDEADBEEF, 1'b1, 16'h0004, 1'b1};
    ext_vecs[1] = '{16'h0020, 32'h12345678, 1'b1, 16'h0008, 1'b1};
    ext_vecs[2] = '{16'h0013, 32'hA5A5A5A5, 1'b0, 16'h0004, 1'b0};
    ext_vecs[3] = '{16'hFFFF, 32'h0F0F0F0F, 1'b1, 16'h3FFF, 1'b1};
    ext_vecs[4] = '{16'h0007, 32'hCAFEF00D, 1'b1, 16'h0001, 1'b1};
    arb_vecs[0] = '{4'b1111, 4'b0001};
    arb_vecs[1] = '{4'b1111, 4'b0010};
    arb_vecs[2] = '{4'b1111, 4'b0100};
    arb_vecs[3] = '{4'b1111, 4'b1000};
    arb_vecs[4] = '{4'b0010, 4'b0010};
    arb_vecs[5] = '{4'b0000, 4'b0000};
    arb_vecs[6] = '{4'b1111, 4'b0100};
    arb_vecs[7] = '{4'b1011, 4'b1000};
    arb_vecs[8] = '{4'b0110, 4'b0010};

    reset_n               = 1'b1;
    run                   = 1'b0;
    ext_write_address     = '0;
    ext_write_data        = '0;
    ext_enable_write_data = 1'b0;
    core_halted           = '0;
    core_exception        = '0;
    bus.core_req          = '0;
    bus.core_write        = '0;
    bus.core_address      = '0;
    bus.core_write_data   = '0;

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    check_output("reset_rvalid", 64'(bus.core_rvalid), 64'd0);
    check_output("reset_all_halted", 64'(all_halted), 64'd0);
    check_output("reset_exception", 64'(exception), 64'd0);
    check_output("reset_exception_core", 64'(exception_core), 64'd0);
    check_output("reset_run_cycles", 64'(run_cycles), 64'd0);
    @(posedge clock); #3 reset_n = 1'b1;
    @(posedge clock); #1;

    // External load mode: passthrough, cores never granted
    bus.core_req = '1;
    for (int v = 0; v < 5; v++) begin
      ext_write_address     = ext_vecs[v].addr;
      ext_write_data        = ext_vecs[v].data;
      ext_enable_write_data = ext_vecs[v].en;
      #1;
      check_output("ext_ram_address", 64'(bus.ram_address), 64'(ext_vecs[v].exp_addr));
      check_output("ext_ram_write", 64'(bus.ram_write), 64'(ext_vecs[v].exp_write));
      check_output("ext_ram_wdata", 64'(bus.ram_write_data), 64'(ext_vecs[v].data));
      check_output("ext_core_grant", 64'(bus.core_grant), 64'd0);
      @(posedge clock); #1;
    end
    bus.core_req          = '0;
    ext_enable_write_data = 1'b0;

    // Round-robin order, pointer hold on idle cycles and wrap-around
    run = 1'b1;
    for (int v = 0; v < 9; v++) begin
      bus.core_req = arb_vecs[v].req;
      #1;
      check_output("arb_grant", 64'(bus.core_grant), 64'(arb_vecs[v].exp_grant));
      @(posedge clock); #1;
    end
    run = 1'b0;
    bus.core_req = '0;
    @(posedge clock); #1;

    // Granted read: grant in cycle N, rvalid/rdata in N+1 only
    run = 1'b1;
    bus.core_req = 4'b0100;
    bus.core_address[2*AW +: AW] = 16'h0020;
    #1;
    check_output("read_grant", 64'(bus.core_grant), 64'h4);
    check_output("read_ram_address", 64'(bus.ram_address), 64'h0008);
    check_output("read_ram_write", 64'(bus.ram_write), 64'd0);
    check_output("read_rvalid_n", 64'(bus.core_rvalid), 64'd0);
    @(posedge clock); #1;
    bus.core_req = '0;
    #1;
    check_output("read_rvalid_n1", 64'(bus.core_rvalid), 64'h4);
    check_output("read_rdata_n1", 64'(bus.core_rdata), 64'h12345678);
    @(posedge clock); #1;
    check_output("read_rvalid_n2", 64'(bus.core_rvalid), 64'd0);

    // Read completes although run falls before the data cycle
    bus.core_req = 4'b0010;
    bus.core_address[1*AW +: AW] = 16'h0010;
    #1;
    check_output("runfall_grant", 64'(bus.core_grant), 64'h2);
    @(posedge clock); #1;
    run = 1'b0;
    bus.core_req = '0;
    #1;
    check_output("runfall_rvalid", 64'(bus.core_rvalid), 64'h2);
    check_output("runfall_rdata", 64'(bus.core_rdata), 64'hDEADBEEF);
    @(posedge clock); #1;

    // Sticky exception, cleared by the next run rising edge
    run = 1'b1;
    core_exception = 4'b0110;
    @(posedge clock); #1;
    core_exception = 4'b1000;
    #1;
    check_output("exc_first", 64'(exception), 64'd1);
    check_output("exc_first_core", 64'(exception_core), 64'd1);
    @(posedge clock); #1;
    core_exception = '0;
    #1;
    check_output("exc_sticky", 64'(exception), 64'd1);
    check_output("exc_sticky_core", 64'(exception_core), 64'd1);
    run = 1'b0;
    @(posedge clock); #1;
    check_output("exc_hold_run0", 64'(exception), 64'd1);
    run = 1'b1;
    @(posedge clock); #1;
    check_output("exc_cleared", 64'(exception), 64'd0);
    check_output("exc_core_cleared", 64'(exception_core), 64'd0);
    run = 1'b0;
    @(posedge clock); #1;

    // Halt detection and run-cycle counter freeze
    run = 1'b1;
    for (int c = 0; c < 10; c++) begin
      core_halted = (c >= 6) ? '1 : '0;
      #1;
      if (c >= 1) check_output("halt_run_cycles", 64'(run_cycles), 64'((c < 7) ? c : 7));
      check_output("halt_all_halted", 64'(all_halted), 64'(c >= 7));
      @(posedge clock); #1;
    end
    check_output("halt_final_cycles", 64'(run_cycles), 64'd7);
    check_output("halt_final_all_halted", 64'(all_halted), 64'd1);
    run = 1'b0;
    @(posedge clock); #1;
    check_output("halt_run0_all_halted", 64'(all_halted), 64'd0);
    check_output("halt_run0_cycles", 64'(run_cycles), 64'd7);
    core_halted = '0;

    // Asynchronous reset right after a granted read discards the pending rvalid
    run = 1'b1;
    bus.core_req = 4'b0001;
    bus.core_address[0 +: AW] = 16'h0010;
    #1;
    check_output("rst_read_grant", 64'(bus.core_grant), 64'h1);
    @(posedge clock); #1;
    bus.core_req = 4'b0010;
    check_output("rst_pre_rvalid", 64'(bus.core_rvalid), 64'h1);
    reset_n = 1'b0;
    #1;
    check_output("rst_rvalid", 64'(bus.core_rvalid), 64'd0);
    check_output("rst_run_cycles", 64'(run_cycles), 64'd0);
    check_output("rst_all_halted", 64'(all_halted), 64'd0);
    check_output("rst_comb_grant", 64'(bus.core_grant), 64'h2);
    @(posedge clock); #1;
    check_output("rst_held_rvalid", 64'(bus.core_rvalid), 64'd0);
    run = 1'b0;
    bus.core_req = '0;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Randomized phase: fresh reset, RAM fill through the loader, then random traffic
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    model_reset();
    @(posedge clock); #1;
    for (int w = 0; w < 256; w++) begin
      ext_write_address     = AW'(w << 2);
      ext_write_data        = $urandom;
      ext_enable_write_data = 1'b1;
      #1;
      model_step();
      @(posedge clock); #1;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      ext_write_address     = AW'($urandom_range(0, 1023));
      ext_write_data        = $urandom;
      ext_enable_write_data = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        if (!bus.core_req[i] || last_k == i) begin
          bus.core_req[i]                  = 1'($urandom_range(0, 1));
          bus.core_write[i]                = 1'($urandom_range(0, 1));
          bus.core_address[i*AW +: AW]     = AW'($urandom_range(0, 1023));
          bus.core_write_data[i*WW +: WW]  = $urandom;
        end
      end
      core_halted    = ($urandom_range(0, 5) == 0) ? '1 : N'($urandom);
      core_exception = ($urandom_range(0, 24) == 0) ? N'($urandom) : '0;
      #1;
      model_step();
      @(posedge clock); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
